// File: rtl/logic_proc_pkg.sv
// Shared definitions for the logic processor: control state encoding and
// the select widths used by both the sequencer and the compute/route stage.
package logic_proc_pkg;

    localparam int F_W = 3;
    localparam int R_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        HOLD  = 2'b10
    } ctrl_state_t;

endpackage

// File: rtl/logic_proc_control_shift_counter.sv
// Counts shifts within one operation. Returns to zero after the final shift
// so the count never exceeds WIDTH-1; clr holds it at zero outside SHIFT.
module shift_counter #(
    parameter int WIDTH = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     clr,
    input  logic                     en,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(WIDTH - 1);

    assign last = (count == LAST_VAL);

    // Count register: reset/clear to zero, advance on en, wrap after the last shift
    always_ff @(posedge Clk) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/logic_proc_control.sv
// Control sequencer for the logic processor. One Execute request produces
// exactly WIDTH shift cycles followed by a HOLD that lasts until Execute is
// released, so a held request cannot retrigger a second operation.
module logic_proc_control #(
    parameter int WIDTH = 8,
    parameter int F_W   = logic_proc_pkg::F_W,
    parameter int R_W   = logic_proc_pkg::R_W
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     Execute,
    input  logic                     LoadA,
    input  logic                     LoadB,
    input  logic [F_W-1:0]           F_In,
    input  logic [R_W-1:0]           R_In,
    output logic                     Ld_A,
    output logic                     Ld_B,
    output logic                     Shift_En,
    output logic [F_W-1:0]           F_Lat,
    output logic [R_W-1:0]           R_Lat,
    output logic                     Busy,
    output logic                     Done,
    output logic [$clog2(WIDTH)-1:0] Shift_Cnt
);

    import logic_proc_pkg::*;

    ctrl_state_t state, state_next;
    logic        cnt_last;
    logic        start_op;

    assign start_op = (state == IDLE) && Execute;

    shift_counter #(
        .WIDTH(WIDTH)
    ) u_shift_counter (
        .Clk  (Clk),
        .Reset(Reset),
        .clr  (state != SHIFT),
        .en   (state == SHIFT),
        .count(Shift_Cnt),
        .last (cnt_last)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Selects are captured only when an operation starts, so switch changes mid-op are ignored
    always_ff @(posedge Clk) begin
        if (Reset) begin
            F_Lat <= '0;
            R_Lat <= '0;
        end else if (start_op) begin
            F_Lat <= F_In;
            R_Lat <= R_In;
        end
    end

    // Next-state and output decode; Execute wins over a simultaneous load request
    always_comb begin
        state_next = state;
        Ld_A       = 1'b0;
        Ld_B       = 1'b0;
        Shift_En   = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            IDLE: begin
                Ld_A = LoadA & ~Execute;
                Ld_B = LoadB & ~Execute;
                if (Execute) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                Shift_En = 1'b1;
                Busy     = 1'b1;
                if (cnt_last) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                Done = 1'b1;
                if (!Execute) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_logic_proc_control.sv
// Bench for logic_proc_control: a vector table for IDLE load/priority
// behaviour and a first operation, then hand-built multi-cycle sequences.
module tb_logic_proc_control;

    localparam int WIDTH = 8;

    logic       Clk = 1'b0;
    logic       Reset, Execute, LoadA, LoadB;
    logic [2:0] F_In;
    logic [1:0] R_In;
    logic       Ld_A, Ld_B, Shift_En, Busy, Done;
    logic [2:0] F_Lat;
    logic [1:0] R_Lat;
    logic [2:0] Shift_Cnt;

    always #5 Clk = ~Clk;

    logic_proc_control #(.WIDTH(WIDTH), .F_W(3), .R_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .Execute(Execute), .LoadA(LoadA), .LoadB(LoadB),
        .F_In(F_In), .R_In(R_In), .Ld_A(Ld_A), .Ld_B(Ld_B), .Shift_En(Shift_En),
        .F_Lat(F_Lat), .R_Lat(R_Lat), .Busy(Busy), .Done(Done), .Shift_Cnt(Shift_Cnt)
    );

    typedef struct packed {
        logic       rst, exe, la, lb;
        logic [2:0] f;
        logic [1:0] r;
    } in_t;

    typedef struct packed {
        logic       ld_a, ld_b, sh, busy, done;
        logic [2:0] f;
        logic [1:0] r;
        logic [2:0] cnt;
    } out_t;

    typedef struct {
        string tag;
        in_t   i;
        out_t  o;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;

    function automatic in_t mi(logic rst, logic exe, logic la, logic lb,
                               logic [2:0] f, logic [1:0] r);
        in_t v;
        v.rst = rst; v.exe = exe; v.la = la; v.lb = lb; v.f = f; v.r = r;
        return v;
    endfunction

    function automatic out_t o_idle(logic la, logic lb, logic [2:0] f, logic [1:0] r);
        out_t v;
        v = '0;
        v.ld_a = la; v.ld_b = lb; v.f = f; v.r = r;
        return v;
    endfunction

    function automatic out_t o_shift(logic [2:0] cnt, logic [2:0] f, logic [1:0] r);
        out_t v;
        v = '0;
        v.sh = 1'b1; v.busy = 1'b1; v.cnt = cnt; v.f = f; v.r = r;
        return v;
    endfunction

    function automatic out_t o_hold(logic [2:0] f, logic [1:0] r);
        out_t v;
        v = '0;
        v.done = 1'b1; v.f = f; v.r = r;
        return v;
    endfunction

    function automatic in_t rand_in();
        in_t v;
        v.rst = 1'b0;
        v.exe = 1'($urandom_range(0, 1));
        v.la  = 1'($urandom_range(0, 1));
        v.lb  = 1'($urandom_range(0, 1));
        v.f   = 3'($urandom_range(0, 7));
        v.r   = 2'($urandom_range(0, 3));
        return v;
    endfunction

    task automatic add_vec(string tag, in_t i, out_t o);
        vec_t v;
        v.tag = tag; v.i = i; v.o = o;
        tbl.push_back(v);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare at the falling edge
    task automatic step(string tag, in_t i, out_t e);
        out_t a, x;
        sb.push_back(e);
        Reset = i.rst; Execute = i.exe; LoadA = i.la; LoadB = i.lb;
        F_In = i.f; R_In = i.r;
        @(negedge Clk);
        x = sb.pop_front();
        a.ld_a = Ld_A; a.ld_b = Ld_B; a.sh = Shift_En; a.busy = Busy; a.done = Done;
        a.f = F_Lat; a.r = R_Lat; a.cnt = Shift_Cnt;
        total++;
        if (a === x) begin
            passed++;
        end else begin
            $display("FAIL %s cycle %0d: got ld_a=%b ld_b=%b sh=%b busy=%b done=%b f=%0d r=%0d cnt=%0d, need ld_a=%b ld_b=%b sh=%b busy=%b done=%b f=%0d r=%0d cnt=%0d",
                     tag, cyc, a.ld_a, a.ld_b, a.sh, a.busy, a.done, a.f, a.r, a.cnt,
                     x.ld_a, x.ld_b, x.sh, x.busy, x.done, x.f, x.r, x.cnt);
        end
        cyc++;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b1; Execute = 1'b0; LoadA = 1'b0; LoadB = 1'b0;
        F_In = '0; R_In = '0;
        @(posedge Clk);
        #1;

        add_vec("rst_idle", mi(1, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd0, 2'd0));
        add_vec("load_a",   mi(0, 0, 1, 0, 3'd0, 2'd0), o_idle(1, 0, 3'd0, 2'd0));
        add_vec("load_b",   mi(0, 0, 0, 1, 3'd0, 2'd0), o_idle(0, 1, 3'd0, 2'd0));
        add_vec("load_ab",  mi(0, 0, 1, 1, 3'd0, 2'd0), o_idle(1, 1, 3'd0, 2'd0));
        add_vec("exe_prio", mi(0, 1, 1, 1, 3'd3, 2'd1), o_idle(0, 0, 3'd0, 2'd0));
        for (int c = 0; c < WIDTH; c++)
            add_vec("tbl_shift", mi(0, 0, 1, 1, 3'd7, 2'd3), o_shift(3'(c), 3'd3, 2'd1));
        add_vec("tbl_hold", mi(0, 0, 1, 1, 3'd0, 2'd0), o_hold(3'd3, 2'd1));
        add_vec("tbl_idle", mi(0, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd3, 2'd1));

        foreach (tbl[n]) step(tbl[n].tag, tbl[n].i, tbl[n].o);

        // Execute held 20 cycles, then released
        step("long_start", mi(0, 1, 0, 0, 3'd5, 2'd2), o_idle(0, 0, 3'd3, 2'd1));
        for (int c = 0; c < WIDTH; c++)
            step("long_shift", mi(0, 1, 0, 0, 3'd5, 2'd2), o_shift(3'(c), 3'd5, 2'd2));
        for (int c = 0; c < 11; c++)
            step("long_hold", mi(0, 1, 0, 0, 3'd5, 2'd2), o_hold(3'd5, 2'd2));
        step("long_release", mi(0, 0, 0, 0, 3'd5, 2'd2), o_hold(3'd5, 2'd2));
        step("long_idle", mi(0, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd5, 2'd2));

        // Inputs toggled randomly during SHIFT must not disturb the operation
        step("tog_start", mi(0, 1, 0, 0, 3'd6, 2'd1), o_idle(0, 0, 3'd5, 2'd2));
        for (int c = 0; c < WIDTH; c++)
            step("tog_shift", rand_in(), o_shift(3'(c), 3'd6, 2'd1));
        step("tog_hold", mi(0, 0, 1, 1, 3'd2, 2'd3), o_hold(3'd6, 2'd1));
        step("tog_idle", mi(0, 0, 1, 0, 3'd2, 2'd3), o_idle(1, 0, 3'd6, 2'd1));

        // Reset in the middle of an operation, then a full fresh operation
        step("abort_start", mi(0, 1, 0, 0, 3'd1, 2'd3), o_idle(0, 0, 3'd6, 2'd1));
        for (int c = 0; c < 4; c++)
            step("abort_shift", mi(0, 0, 0, 0, 3'd0, 2'd0), o_shift(3'(c), 3'd1, 2'd3));
        step("abort_rst", mi(1, 0, 0, 0, 3'd0, 2'd0), o_shift(3'd4, 3'd1, 2'd3));
        step("abort_after", mi(0, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd0, 2'd0));
        step("abort_after2", mi(0, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd0, 2'd0));
        step("fresh_start", mi(0, 1, 0, 0, 3'd2, 2'd1), o_idle(0, 0, 3'd0, 2'd0));
        for (int c = 0; c < WIDTH; c++)
            step("fresh_shift", mi(0, 0, 0, 0, 3'd0, 2'd0), o_shift(3'(c), 3'd2, 2'd1));
        step("fresh_hold", mi(0, 0, 0, 0, 3'd0, 2'd0), o_hold(3'd2, 2'd1));
        step("fresh_idle", mi(0, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd2, 2'd1));

        // Execute held across two operation lengths gives one op; re-arm after release
        step("hold2_start", mi(0, 1, 0, 0, 3'd4, 2'd0), o_idle(0, 0, 3'd2, 2'd1));
        for (int c = 0; c < WIDTH; c++)
            step("hold2_shift", mi(0, 1, 0, 0, 3'd4, 2'd0), o_shift(3'(c), 3'd4, 2'd0));
        for (int c = 0; c < 2 * WIDTH; c++)
            step("hold2_noretrig", mi(0, 1, 0, 0, 3'd4, 2'd0), o_hold(3'd4, 2'd0));
        step("hold2_release", mi(0, 0, 0, 0, 3'd4, 2'd0), o_hold(3'd4, 2'd0));
        step("hold2_idle", mi(0, 0, 0, 0, 3'd4, 2'd0), o_idle(0, 0, 3'd4, 2'd0));
        step("rearm_start", mi(0, 1, 0, 0, 3'd7, 2'd3), o_idle(0, 0, 3'd4, 2'd0));
        for (int c = 0; c < WIDTH; c++)
            step("rearm_shift", mi(0, 1, 0, 0, 3'd7, 2'd3), o_shift(3'(c), 3'd7, 2'd3));
        step("hold_rst", mi(1, 1, 0, 0, 3'd7, 2'd3), o_hold(3'd7, 2'd3));
        step("after_hold_rst", mi(0, 0, 0, 0, 3'd0, 2'd0), o_idle(0, 0, 3'd0, 2'd0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
